// File: rtl/i2c_target_rx.sv
// I2C target receiver: synchronises scl/sda, detects bus conditions,
// matches a 7-bit write address and ACKs/streams received data bytes.
module i2c_target_rx #(
    parameter logic [6:0] ADDRESS = 7'h27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       ack_hi_q, ack_hi_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       addr_match_q, addr_match_d;
    logic       busy_q, busy_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;

    logic scl_meta_q, scl_meta_d;
    logic scl_sync_q, scl_sync_d;
    logic scl_hist_q, scl_hist_d;
    logic sda_meta_q, sda_meta_d;
    logic sda_sync_q, sda_sync_d;
    logic sda_hist_q, sda_hist_d;

    logic scl_rise, scl_fall;
    logic sda_rise, sda_fall;
    logic bus_start, bus_stop;

    // Two-flop synchroniser plus one history flop per bus line.
    always_comb begin
        scl_meta_d = scl_in;
        scl_sync_d = scl_meta_q;
        scl_hist_d = scl_sync_q;
        sda_meta_d = sda_in;
        sda_sync_d = sda_meta_q;
        sda_hist_d = sda_sync_q;
    end

    // Synchroniser registers; idle bus level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    assign scl_rise  = scl_sync_q & ~scl_hist_q;
    assign scl_fall  = ~scl_sync_q & scl_hist_q;
    assign sda_rise  = sda_sync_q & ~sda_hist_q;
    assign sda_fall  = ~sda_sync_q & sda_hist_q;
    assign bus_start = sda_fall & scl_sync_q;
    assign bus_stop  = sda_rise & scl_sync_q;

    // Next-state logic: bus conditions override every state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        ack_hi_d     = ack_hi_q;
        sda_oe_d     = sda_oe_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        addr_match_d = addr_match_q;
        busy_d       = busy_q;
        start_det_d  = 1'b0;
        stop_det_d   = 1'b0;
        if (bus_start) begin
            state_d      = ADDR;
            cnt_d        = 3'd7;
            shift_d      = 8'h00;
            ack_hi_d     = 1'b0;
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b0;
            busy_d       = 1'b1;
            start_det_d  = 1'b1;
        end else if (bus_stop) begin
            state_d      = IDLE;
            ack_hi_d     = 1'b0;
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b0;
            busy_d       = 1'b0;
            stop_det_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_sync_q};
                        cnt_d   = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            if (shift_q[6:0] == ADDRESS && !sda_sync_q)
                                state_d = ADDR_ACK;
                            else
                                state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (ack_hi_q) begin
                            sda_oe_d = 1'b0;
                            ack_hi_d = 1'b0;
                            state_d  = DATA;
                            cnt_d    = 3'd7;
                        end else if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            if (state_q == ADDR_ACK)
                                addr_match_d = 1'b1;
                        end
                    end else if (scl_rise && sda_oe_q) begin
                        ack_hi_d = 1'b1;
                    end
                end
                DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_sync_q};
                        cnt_d   = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            if (rx_ready) begin
                                rx_data_d  = {shift_q[6:0], sda_sync_q};
                                rx_valid_d = 1'b1;
                                state_d    = DATA_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Protocol state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd7;
            shift_q      <= 8'h00;
            ack_hi_q     <= 1'b0;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
            start_det_q  <= 1'b0;
            stop_det_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            ack_hi_q     <= ack_hi_d;
            sda_oe_q     <= sda_oe_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            busy_q       <= busy_d;
            start_det_q  <= start_det_d;
            stop_det_q   <= stop_det_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign addr_match = addr_match_q;
    assign busy       = busy_q;
    assign start_det  = start_det_q;
    assign stop_det   = stop_det_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: a behavioural I2C initiator drives the bus,
// received bytes are checked against a queue of expected bytes.
module tb_i2c_target_rx;

    localparam time Q = 50ns;

    logic       clk;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_oe;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       busy;
    logic       start_det;
    logic       stop_det;
    logic       sda_bus;

    int checks;
    int errors;
    int n_start;
    int n_stop;
    int exp_start;
    int exp_stop;
    logic oe_seen;
    logic prev_scl;
    logic prev_oe;
    logic [7:0] exp_q[$];

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_rx dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_m),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .addr_match (addr_match),
        .busy       (busy),
        .start_det  (start_det),
        .stop_det   (stop_det)
    );

    initial clk = 1'b0;
    always #5ns clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on rx_valid, counts bus-condition pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_valid_unexpected got %0h expected none",
                             rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        errors++;
                        $display("FAIL rx_byte got %0h expected %0h",
                                 rx_data, e);
                    end
                end
            end
            if (start_det) n_start++;
            if (stop_det) n_stop++;
            if (sda_oe) oe_seen = 1'b1;
            if (scl_m && prev_scl && sda_oe !== prev_oe) begin
                errors++;
                $display("FAIL oe_while_scl_high got %0b expected %0b",
                         sda_oe, prev_oe);
            end
        end
        prev_scl = scl_m;
        prev_oe  = sda_oe;
    end

    task automatic bus_start();
        sda_m = 1'b1;
        #Q;
        scl_m = 1'b1;
        #Q;
        sda_m = 1'b0;
        #Q;
        scl_m = 1'b0;
        #Q;
        exp_start++;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        #Q;
        scl_m = 1'b1;
        #Q;
        sda_m = 1'b1;
        #Q;
        #Q;
        exp_stop++;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        #Q;
        scl_m = 1'b1;
        #(2 * Q);
        scl_m = 1'b0;
        #Q;
    endtask

    task automatic ack_bit(output logic a);
        sda_m = 1'b1;
        #Q;
        scl_m = 1'b1;
        #Q;
        a = sda_bus;
        #Q;
        scl_m = 1'b0;
        #Q;
    endtask

    task automatic send_byte(input string name, input logic [7:0] b,
                             input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_bit(a);
        chk(name, {31'd0, a}, {31'd0, exp_ack});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        n_start   = 0;
        n_stop    = 0;
        exp_start = 0;
        exp_stop  = 0;
        oe_seen   = 1'b0;
        prev_scl  = 1'b1;
        prev_oe   = 1'b0;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        rx_ready  = 1'b1;
        reset     = 1'b1;
        #23ns;
        chk("rst_sda_oe", {31'd0, sda_oe}, 0);
        chk("rst_rx_data", {24'd0, rx_data}, 0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 0);
        chk("rst_addr_match", {31'd0, addr_match}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_start_det", {31'd0, start_det}, 0);
        chk("rst_stop_det", {31'd0, stop_det}, 0);
        reset = 1'b0;
        #40ns;

        // 1: single byte to our address
        bus_start();
        chk("t1_busy", {31'd0, busy}, 1);
        send_byte("t1_addr_ack", 8'h4E, 1'b0);
        chk("t1_addr_match", {31'd0, addr_match}, 1);
        exp_q.push_back(8'hA5);
        send_byte("t1_data_ack", 8'hA5, 1'b0);
        bus_stop();
        chk("t1_busy_end", {31'd0, busy}, 0);
        chk("t1_rx_data", {24'd0, rx_data}, 32'hA5);
        chk("t1_match_end", {31'd0, addr_match}, 0);
        chk("t1_starts", n_start, exp_start);
        chk("t1_stops", n_stop, exp_stop);

        // 2: other address is ignored
        oe_seen = 1'b0;
        bus_start();
        send_byte("t2_addr_nack", 8'h4C, 1'b1);
        chk("t2_addr_match", {31'd0, addr_match}, 0);
        send_byte("t2_data_nack", 8'hFF, 1'b1);
        bus_stop();
        chk("t2_oe_never", {31'd0, oe_seen}, 0);

        // 3: three bytes in one transfer
        bus_start();
        send_byte("t3_addr_ack", 8'h4E, 1'b0);
        exp_q.push_back(8'h01);
        send_byte("t3_d0_ack", 8'h01, 1'b0);
        exp_q.push_back(8'h80);
        send_byte("t3_d1_ack", 8'h80, 1'b0);
        exp_q.push_back(8'h3C);
        send_byte("t3_d2_ack", 8'h3C, 1'b0);
        bus_stop();
        chk("t3_rx_data", {24'd0, rx_data}, 32'h3C);

        // 4: sink not ready -> NACK, rest ignored
        bus_start();
        send_byte("t4_addr_ack", 8'h4E, 1'b0);
        rx_ready = 1'b0;
        send_byte("t4_data_nack", 8'h55, 1'b1);
        rx_ready = 1'b1;
        chk("t4_match_held", {31'd0, addr_match}, 1);
        send_byte("t4_next_nack", 8'h12, 1'b1);
        bus_stop();
        chk("t4_rx_data", {24'd0, rx_data}, 32'h3C);

        // 5: repeated START drops a partial byte
        bus_start();
        send_byte("t5_addr_ack", 8'h4E, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        bus_start();
        chk("t5_match_clr", {31'd0, addr_match}, 0);
        send_byte("t5_addr2_ack", 8'h4E, 1'b0);
        exp_q.push_back(8'h99);
        send_byte("t5_data_ack", 8'h99, 1'b0);
        bus_stop();
        chk("t5_rx_data", {24'd0, rx_data}, 32'h99);
        chk("t5_starts", n_start, exp_start);

        // 6: reset during an address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(8'h4E >> i);
        chk("t6_oe_before", {31'd0, sda_oe}, 1);
        reset = 1'b1;
        #1ns;
        chk("t6_oe_async", {31'd0, sda_oe}, 0);
        chk("t6_busy_async", {31'd0, busy}, 0);
        chk("t6_match_async", {31'd0, addr_match}, 0);
        chk("t6_rx_data_async", {24'd0, rx_data}, 0);
        #19ns;
        reset = 1'b0;
        #20ns;
        bus_start();
        send_byte("t6_addr_ack", 8'h4E, 1'b0);
        exp_q.push_back(8'h5A);
        send_byte("t6_data_ack", 8'h5A, 1'b0);
        bus_stop();
        chk("t6_rx_data", {24'd0, rx_data}, 32'h5A);

        #200ns;
        chk("rx_pending", exp_q.size(), 0);
        chk("total_starts", n_start, exp_start);
        chk("total_stops", n_stop, exp_stop);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
